// File: rtl/sprite_pkg.sv
// Shared types and constants for the digit sprite renderer.
//   COLOR_W              pixel colour width (4:4:4 RGB)
//   SPRITE_DIM           sprite edge length in pixels
//   TRANSPARENT_DEFAULT  ROM colour that is treated as see-through
//   digit_t              4-bit digit value; 10-15 are accepted but drawn blank
//   upd_state_t          states of the digit handshake/frame-latch FSM
package sprite_pkg;

  localparam int COLOR_W    = 12;
  localparam int SPRITE_DIM = 32;

  localparam logic [COLOR_W-1:0] TRANSPARENT_DEFAULT = 12'hFFF;

  typedef logic [3:0] digit_t;

  localparam digit_t MAX_SHOWN_DIGIT = 4'd9;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } upd_state_t;

endpackage

// File: rtl/digit_update_ctrl.sv
// Digit handshake and frame latch.
// A digit offered while idle is captured into a pending register; the
// pending value only becomes the active digit at the next frame_tick so the
// displayed glyph never changes mid-frame.
//   clk, reset_n   clock, asynchronous active-low reset
//   digit_in       requested digit
//   digit_valid    digit_in is offered
//   frame_tick     one-cycle pulse at start of vertical blank
//   digit_ready    high exactly while idle (registered)
//   active_digit   digit currently displayed
module digit_update_ctrl
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       frame_tick,
  output logic       digit_ready,
  output logic [3:0] active_digit
);

  upd_state_t state;
  digit_t     pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      pending      <= '0;
      active_digit <= '0;
      digit_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // A frame_tick in the same cycle is deliberately ignored here; the
          // captured digit waits for the following tick.
          if (digit_valid) begin
            pending     <= digit_in;
            state       <= ST_PENDING;
            digit_ready <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (frame_tick) begin
            active_digit <= pending;
            state        <= ST_IDLE;
            digit_ready  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          digit_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/digit_sprite_renderer.sv
// Renders one 32x32 digit sprite from an external registered ROM.
// Optional feature: define DIGIT_BLINK_EN to blank the sprite during the
// upper half of a 32-frame cycle while blink is high.
//   clk, reset_n        clock, asynchronous active-low reset
//   x, y, video_on      current pixel from the VGA sync unit
//   frame_tick          start-of-vertical-blank pulse
//   digit_in/valid/ready digit update handshake
//   blink               blink request (ignored without DIGIT_BLINK_EN)
//   rom_sel/row/col     ROM address (row/col combinational from x, y)
//   rom_data            ROM colour, valid one cycle after the address
//   sprite_on, rgb_out  registered pixel result, two cycles after x, y
module digit_sprite_renderer
  import sprite_pkg::*;
#(
  parameter logic [9:0]         X0          = 10'd300,
  parameter logic [9:0]         Y0          = 10'd20,
  parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               video_on,
  input  logic               frame_tick,
  input  logic [3:0]         digit_in,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic               blink,
  output logic [3:0]         rom_sel,
  output logic [4:0]         rom_row,
  output logic [4:0]         rom_col,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               sprite_on,
  output logic [COLOR_W-1:0] rgb_out
);

  // 11-bit box limits so X0+32 / Y0+32 cannot wrap near the 10-bit limit.
  localparam logic [10:0] X_LO = {1'b0, X0};
  localparam logic [10:0] X_HI = X_LO + 11'(SPRITE_DIM);
  localparam logic [10:0] Y_LO = {1'b0, Y0};
  localparam logic [10:0] Y_HI = Y_LO + 11'(SPRITE_DIM);

  digit_t active_digit;
  logic   in_box;
  logic   box_d1;
  logic   blank_now;
  logic   show;

  digit_update_ctrl u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .frame_tick   (frame_tick),
    .digit_ready  (digit_ready),
    .active_digit (active_digit)
  );

  assign rom_sel = active_digit;

  // Only the low five bits of the offset are needed, and those depend only
  // on the low five bits of the operands.
  assign rom_row = y[4:0] - Y0[4:0];
  assign rom_col = x[4:0] - X0[4:0];

  always_comb begin
    in_box = video_on
          && ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI)
          && ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
  end

`ifdef DIGIT_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign blank_now = blink & frame_cnt[4];
`else
  logic blink_unused;
  assign blink_unused = blink;
  assign blank_now    = 1'b0;
`endif

  // Stage 1 delays in_box to line up with rom_data; stage 2 is the output
  // register itself.
  always_comb begin
    show = box_d1
        && (rom_data != TRANSPARENT)
        && (active_digit <= MAX_SHOWN_DIGIT)
        && !blank_now;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      box_d1    <= 1'b0;
      sprite_on <= 1'b0;
      rgb_out   <= '0;
    end else begin
      box_d1    <= in_box;
      sprite_on <= show;
      rgb_out   <= show ? rom_data : '0;
    end
  end

endmodule
